vcpu_alu_seq: RTL and testbench
===============================

Name: vcpu_alu_seq

Overview:
Parametrised, registered successor to the vcpu ALU, with valid/ready handshakes on both input and output. Ops are ADD, SUB, AND, OR, XOR, SHL, SHR and an iterative MUL. It produces a registered result plus a flag set (eq, zero, carry, neg). It sits between the vcpu decode stage and the register-file writeback. Multi-cycle ops stall upstream through in_ready.

Parameters:
WIDTH, 8, operand/result width in bits (>=4)
MUL_ENABLE, 1, 1 = op 3'b111 is a shift-add multiply; 0 = op 3'b111 is a 1-cycle no-op

Ports:
clk  in  1  clock, all state on rising edge
nreset  in  1  asynchronous active-low reset
in_valid  in  1  operation request
in_ready  out  1  block can accept a request
op  in  3  000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 SHL, 110 SHR, 111 MUL
a  in  WIDTH  operand A
b  in  WIDTH  operand B; shift amount for SHL/SHR
out_valid  out  1  result registers hold a new result
out_ready  in  1  consumer accepts the result
c  out  WIDTH  result; low half of the product for MUL
c_hi  out  WIDTH  high half of the product for MUL; 0 for all other ops
flag_eq  out  1  captured a == captured b
flag_zero  out  1  result == 0 ({c_hi,c} for MUL)
flag_carry  out  1  carry, borrow or shift-out (see below)
flag_neg  out  1  c[WIDTH-1]

Behaviour:
- Reset: nreset is asynchronous and active-low. While asserted, state = IDLE; c, c_hi, all flags and out_valid = 0; MUL accumulators cleared.
- in_ready = (state == IDLE). It is combinational from state only and is 1 immediately after reset.
- States:
  - IDLE: accept on in_valid & in_ready and capture op, a, b. MUL with MUL_ENABLE=1 goes to MUL; every other op computes from the captured operands and goes to DONE.
  - MUL: one shift-add step per cycle. After WIDTH steps, load {c_hi,c} and go to DONE.
  - DONE: out_valid = 1. Go to IDLE on out_valid & out_ready.
- Latency, counted from the accept edge:
  - Non-MUL ops: out_valid is high 1 cycle later.
  - MUL: out_valid is high WIDTH+1 cycles later.
- No same-cycle accept while out_valid = 1. Minimum issue interval is 2 cycles for non-MUL ops.
- Backpressure: while out_valid & !out_ready, c, c_hi and all flags hold stable and in_ready = 0.
- Inputs are ignored unless the request is accepted. in_valid asserted during MUL/DONE is not consumed.
- Output registers (c, c_hi, flags) update only on the cycle entering DONE. They keep their last values in IDLE.
- out_valid drops the cycle after the handshake.
- Arithmetic is unsigned, modulo 2^WIDTH:
  - ADD: carry = bit WIDTH of a+b.
  - SUB: c = a-b; carry = borrow (a < b).
  - AND/OR/XOR: carry = 0.
- Shifts (amount = b, full width, unsigned):
  - b = 0: c = a, carry = 0.
  - 0 < b <= WIDTH: SHL carry = a[WIDTH-b]; SHR carry = a[b-1]; vacated bits filled with 0.
  - b > WIDTH: c = 0, carry = 0.
- MUL: {c_hi,c} = a*b at full 2*WIDTH width; carry = (c_hi != 0).
- MUL_ENABLE=0, op 111: 1-cycle result with c = 0, c_hi = 0, carry = 0; zero and eq evaluated normally.
- flag_eq compares the captured operands for every op.
- Reset mid-operation: reset asserted in MUL or DONE aborts the op. No out_valid is produced for it; state returns to IDLE.

Test Plan:
- WIDTH=8, a=23, b=44, ADD, out_ready=1 -> out_valid 1 cycle after accept; c=67, carry=0, zero=0, eq=0, neg=0; in_ready back high the cycle after the handshake.
- a=23, b=44, SUB -> c=235 (0xEB), carry=1, neg=1. Then a=b=44, SUB -> c=0, zero=1, eq=1, carry=0.
- a=23, b=44, MUL -> in_ready=0 for 9 cycles; out_valid 9 cycles after accept; c=0xF4, c_hi=0x03, carry=1. Also a=200, b=56, ADD -> c=0, carry=1, zero=1.
- SHL a=0x81, b=1 -> c=0x02, carry=1.
- SHR a=0x81, b=8 -> c=0x00, carry=1.
- SHR a=0xFF, b=9 -> c=0, carry=0.
- SHL b=0 -> c=a, carry=0.
- Backpressure: XOR a=0xF0, b=0x3C with out_ready=0 for 5 cycles -> c=0xCC held stable, out_valid held, in_ready=0, and a concurrent in_valid is not consumed. out_ready=1 -> handshake, then the next request is accepted.
- Reset mid-op: assert nreset low 3 cycles into a MUL -> out_valid, c, c_hi and flags go to 0 immediately (asynchronous). After release, in_ready=1 and a new ADD 1+1 yields c=2.

Source files
------------

// File: rtl/vcpu_alu_seq.sv
`default_nettype none
// ============================================================================
// vcpu_alu_seq : registered valid/ready ALU with iterative shift-add multiply
// Revision 1.0
// ============================================================================
module vcpu_alu_seq #(
   parameter int WIDTH      = 8,
   parameter int MUL_ENABLE = 1
) (
   input  logic             clk,
   input  logic             nreset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] c,
   output logic [WIDTH-1:0] c_hi,
   output logic             flag_eq,
   output logic             flag_zero,
   output logic             flag_carry,
   output logic             flag_neg
);

   localparam int   CNT_W  = $clog2(WIDTH);
   localparam logic MUL_EN = (MUL_ENABLE != 0);

   localparam logic [2:0] OP_ADD = 3'b000;
   localparam logic [2:0] OP_SUB = 3'b001;
   localparam logic [2:0] OP_AND = 3'b010;
   localparam logic [2:0] OP_OR  = 3'b011;
   localparam logic [2:0] OP_XOR = 3'b100;
   localparam logic [2:0] OP_SHL = 3'b101;
   localparam logic [2:0] OP_SHR = 3'b110;
   localparam logic [2:0] OP_MUL = 3'b111;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_MUL  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t               state_q, state_d;
   logic [WIDTH-1:0]     a_q, a_d, b_q, b_d;
   logic [WIDTH-1:0]     mplier_q, mplier_d;
   logic [2*WIDTH-1:0]   acc_q, acc_d, mcand_q, mcand_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic [WIDTH-1:0]     c_q, c_d, c_hi_q, c_hi_d;
   logic                 eq_q, eq_d, zero_q, zero_d, carry_q, carry_d, neg_q, neg_d;

   logic [WIDTH:0]       alu_sum, alu_diff, alu_shl, alu_shr;
   logic [WIDTH-1:0]     alu_res;
   logic                 alu_carry;
   logic [2*WIDTH-1:0]   mul_next;

   // Single-cycle ops; the extra bit of each extended vector carries out the
   // carry/borrow/shifted-out bit. Amounts above WIDTH shift everything out.
   always_comb begin
      alu_sum   = {1'b0, a} + {1'b0, b};
      alu_diff  = {1'b0, a} - {1'b0, b};
      alu_shl   = {1'b0, a} << b;
      alu_shr   = {a, 1'b0} >> b;
      alu_res   = '0;
      alu_carry = 1'b0;
      case (op)
         OP_ADD: begin alu_res = alu_sum[WIDTH-1:0];  alu_carry = alu_sum[WIDTH];  end
         OP_SUB: begin alu_res = alu_diff[WIDTH-1:0]; alu_carry = alu_diff[WIDTH]; end
         OP_AND: alu_res = a & b;
         OP_OR:  alu_res = a | b;
         OP_XOR: alu_res = a ^ b;
         OP_SHL: begin alu_res = alu_shl[WIDTH-1:0]; alu_carry = alu_shl[WIDTH]; end
         OP_SHR: begin alu_res = alu_shr[WIDTH:1];   alu_carry = alu_shr[0];     end
         default: begin alu_res = '0; alu_carry = 1'b0; end
      endcase
   end

   assign mul_next = acc_q + (mplier_q[0] ? mcand_q : '0);

   always_comb begin
      state_d  = state_q;
      a_d      = a_q;
      b_d      = b_q;
      mplier_d = mplier_q;
      acc_d    = acc_q;
      mcand_d  = mcand_q;
      cnt_d    = cnt_q;
      c_d      = c_q;
      c_hi_d   = c_hi_q;
      eq_d     = eq_q;
      zero_d   = zero_q;
      carry_d  = carry_q;
      neg_d    = neg_q;
      case (state_q)
         ST_IDLE: begin
            if (in_valid) begin
               a_d = a;
               b_d = b;
               if ((op == OP_MUL) && MUL_EN) begin
                  acc_d    = '0;
                  mcand_d  = {{WIDTH{1'b0}}, a};
                  mplier_d = b;
                  cnt_d    = '0;
                  state_d  = ST_MUL;
               end else begin
                  c_d     = alu_res;
                  c_hi_d  = '0;
                  eq_d    = (a == b);
                  zero_d  = (alu_res == '0);
                  carry_d = alu_carry;
                  neg_d   = alu_res[WIDTH-1];
                  state_d = ST_DONE;
               end
            end
         end
         ST_MUL: begin
            acc_d    = mul_next;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + CNT_W'(1);
            // Last partial product is folded straight into the result registers.
            if (cnt_q == CNT_W'(WIDTH-1)) begin
               c_d     = mul_next[WIDTH-1:0];
               c_hi_d  = mul_next[2*WIDTH-1:WIDTH];
               eq_d    = (a_q == b_q);
               zero_d  = (mul_next == '0);
               carry_d = (mul_next[2*WIDTH-1:WIDTH] != '0);
               neg_d   = mul_next[WIDTH-1];
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            if (out_ready) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         state_q  <= ST_IDLE;
         a_q      <= '0;
         b_q      <= '0;
         mplier_q <= '0;
         acc_q    <= '0;
         mcand_q  <= '0;
         cnt_q    <= '0;
         c_q      <= '0;
         c_hi_q   <= '0;
         eq_q     <= 1'b0;
         zero_q   <= 1'b0;
         carry_q  <= 1'b0;
         neg_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         a_q      <= a_d;
         b_q      <= b_d;
         mplier_q <= mplier_d;
         acc_q    <= acc_d;
         mcand_q  <= mcand_d;
         cnt_q    <= cnt_d;
         c_q      <= c_d;
         c_hi_q   <= c_hi_d;
         eq_q     <= eq_d;
         zero_q   <= zero_d;
         carry_q  <= carry_d;
         neg_q    <= neg_d;
      end
   end

   assign in_ready   = (state_q == ST_IDLE);
   assign out_valid  = (state_q == ST_DONE);
   assign c          = c_q;
   assign c_hi       = c_hi_q;
   assign flag_eq    = eq_q;
   assign flag_zero  = zero_q;
   assign flag_carry = carry_q;
   assign flag_neg   = neg_q;

endmodule
`default_nettype wire

// File: tb/tb_vcpu_alu_seq.sv
`default_nettype none
// ============================================================================
// tb_vcpu_alu_seq : directed self-checking bench for vcpu_alu_seq (WIDTH=8)
// Revision 1.0
// ============================================================================
module tb_vcpu_alu_seq;

   localparam logic [2:0] OP_ADD = 3'b000;
   localparam logic [2:0] OP_SUB = 3'b001;
   localparam logic [2:0] OP_AND = 3'b010;
   localparam logic [2:0] OP_OR  = 3'b011;
   localparam logic [2:0] OP_XOR = 3'b100;
   localparam logic [2:0] OP_SHL = 3'b101;
   localparam logic [2:0] OP_SHR = 3'b110;
   localparam logic [2:0] OP_MUL = 3'b111;

   logic       clk = 1'b0;
   logic       nreset;
   logic       in_valid;
   logic       in_ready;
   logic [2:0] op;
   logic [7:0] a, b;
   logic       out_valid;
   logic       out_ready;
   logic [7:0] c, c_hi;
   logic       flag_eq, flag_zero, flag_carry, flag_neg;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   vcpu_alu_seq #(.WIDTH(8), .MUL_ENABLE(1)) dut (
      .clk        (clk),
      .nreset     (nreset),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .op         (op),
      .a          (a),
      .b          (b),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .c          (c),
      .c_hi       (c_hi),
      .flag_eq    (flag_eq),
      .flag_zero  (flag_zero),
      .flag_carry (flag_carry),
      .flag_neg   (flag_neg)
   );

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Present one request, wait for the accept edge, then for out_valid.
   task automatic issue(input logic [2:0] o, input logic [7:0] aa, input logic [7:0] bb,
                        output int lat, output int busy);
      op = o; a = aa; b = bb; in_valid = 1'b1;
      check_val("in_ready_pre", in_ready, 1);
      step();
      in_valid = 1'b0; a = ~aa; b = ~bb;
      lat  = 1;
      busy = in_ready ? 0 : 1;
      while (!out_valid && lat < 50) begin
         step();
         lat++;
         if (!in_ready) busy++;
      end
      check_val("out_valid_seen", out_valid, 1);
   endtask

   task automatic chk_res(input string tag, input logic [7:0] ec, input logic [7:0] ehi,
                          input logic eeq, input logic ez, input logic ecy, input logic eng);
      check_val({tag, ".c"},     c,          ec);
      check_val({tag, ".c_hi"},  c_hi,       ehi);
      check_val({tag, ".eq"},    flag_eq,    eeq);
      check_val({tag, ".zero"},  flag_zero,  ez);
      check_val({tag, ".carry"}, flag_carry, ecy);
      check_val({tag, ".neg"},   flag_neg,   eng);
   endtask

   task automatic handshake(input string tag);
      step();
      check_val({tag, ".ov_drop"},  out_valid, 0);
      check_val({tag, ".rdy_back"}, in_ready,  1);
   endtask

   task automatic run_one(input string tag, input logic [2:0] o, input logic [7:0] aa,
                          input logic [7:0] bb, input int exp_lat, input logic [7:0] ec,
                          input logic [7:0] ehi, input logic eeq, input logic ez,
                          input logic ecy, input logic eng);
      int lat, busy;
      issue(o, aa, bb, lat, busy);
      check_val({tag, ".lat"},  lat,  exp_lat);
      check_val({tag, ".busy"}, busy, exp_lat);
      chk_res(tag, ec, ehi, eeq, ez, ecy, eng);
      handshake(tag);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int lat, busy, seen;
      nreset = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      op = 3'b000; a = 8'h00; b = 8'h00;
      #3;
      check_val("rst.out_valid", out_valid, 0);
      check_val("rst.in_ready",  in_ready,  1);
      chk_res("rst", 8'h00, 8'h00, 0, 0, 0, 0);
      repeat (2) @(posedge clk);
      #1 nreset = 1'b1;
      step();

      //        tag      op      a      b      lat c      c_hi   eq z  cy n
      run_one("add",    OP_ADD, 8'd23,  8'd44, 1, 8'd67,  8'h00, 0, 0, 0, 0);
      run_one("sub",    OP_SUB, 8'd23,  8'd44, 1, 8'hEB,  8'h00, 0, 0, 1, 1);
      run_one("sub_eq", OP_SUB, 8'd44,  8'd44, 1, 8'h00,  8'h00, 1, 1, 0, 0);
      run_one("mul",    OP_MUL, 8'd23,  8'd44, 9, 8'hF4,  8'h03, 0, 0, 1, 1);
      run_one("add_cy", OP_ADD, 8'd200, 8'd56, 1, 8'h00,  8'h00, 0, 1, 1, 0);
      run_one("shl1",   OP_SHL, 8'h81,  8'd1,  1, 8'h02,  8'h00, 0, 0, 1, 0);
      run_one("shr8",   OP_SHR, 8'h81,  8'd8,  1, 8'h00,  8'h00, 0, 1, 1, 0);
      run_one("shr9",   OP_SHR, 8'hFF,  8'd9,  1, 8'h00,  8'h00, 0, 1, 0, 0);
      run_one("shl0",   OP_SHL, 8'h5A,  8'd0,  1, 8'h5A,  8'h00, 0, 0, 0, 0);
      run_one("shl8",   OP_SHL, 8'h01,  8'd8,  1, 8'h00,  8'h00, 0, 1, 1, 0);
      run_one("and",    OP_AND, 8'hF0,  8'h3C, 1, 8'h30,  8'h00, 0, 0, 0, 0);
      run_one("or",     OP_OR,  8'hF0,  8'h3C, 1, 8'hFC,  8'h00, 0, 0, 0, 1);
      run_one("mul_z",  OP_MUL, 8'd0,   8'd5,  9, 8'h00,  8'h00, 0, 1, 0, 0);

      // Backpressure: result must hold and a competing request must be ignored.
      out_ready = 1'b0;
      issue(OP_XOR, 8'hF0, 8'h3C, lat, busy);
      check_val("bp.lat", lat, 1);
      for (int i = 0; i < 5; i++) begin
         op = OP_ADD; a = 8'd1; b = 8'd1; in_valid = 1'b1;
         check_val("bp.out_valid", out_valid, 1);
         check_val("bp.in_ready",  in_ready,  0);
         chk_res("bp", 8'hCC, 8'h00, 0, 0, 0, 1);
         step();
      end
      in_valid = 1'b0; out_ready = 1'b1;
      check_val("bp.still_valid", out_valid, 1);
      handshake("bp");
      check_val("bp.idle_hold_c", c, 8'hCC);
      run_one("bp_next", OP_ADD, 8'd3, 8'd4, 1, 8'd7, 8'h00, 0, 0, 0, 0);
      run_one("mul_ff",  OP_MUL, 8'hFF, 8'hFF, 9, 8'h01, 8'hFE, 1, 0, 1, 0);

      // Asynchronous reset three cycles into a multiply.
      op = OP_MUL; a = 8'd23; b = 8'd44; in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      repeat (2) step();
      check_val("rmid.busy", in_ready, 0);
      nreset = 1'b0;
      #1;
      check_val("rmid.out_valid", out_valid, 0);
      check_val("rmid.in_ready",  in_ready,  1);
      chk_res("rmid", 8'h00, 8'h00, 0, 0, 0, 0);
      step();
      nreset = 1'b1;
      seen = 0;
      for (int i = 0; i < 12; i++) begin
         step();
         if (out_valid) seen++;
      end
      check_val("rmid.no_stale", seen, 0);
      run_one("post_rst", OP_ADD, 8'd1, 8'd1, 1, 8'd2, 8'h00, 1, 0, 0, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
